cdc_hs_tx: RTL



---
 rtl/cdc_hs_tx_if.sv | 24 ++
 rtl/cdc_hs_tx.sv | 129 ++++++++++++
 2 files changed

// File: rtl/cdc_hs_tx_if.sv
// Source-side bundle for the cdc_hs_tx 4-phase req/ack transmitter.
// The master view belongs to the transmitter; the slave view belongs to the upstream/receiver side.
interface cdc_hs_tx_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] in_data;
  logic                  req_out;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  ack_in;
  logic                  busy;
  logic                  xfer_done;

  modport master (
    input  in_valid, in_data, ack_in,
    output in_ready, req_out, data_out, busy, xfer_done
  );

  modport slave (
    output in_valid, in_data, ack_in,
    input  in_ready, req_out, data_out, busy, xfer_done
  );
endinterface

// File: rtl/cdc_hs_tx.sv
// Source-domain transmitter of a 4-phase req/ack crossing: holds data_out while req_out is high.
// Optional one-entry skid buffer enabled by defining CDC_HS_TX_SKID_EN.
module cdc_hs_tx #(
  parameter int DATA_WIDTH      = 32,
  parameter int NUM_SYNC_STAGES = 2
) (
  input  logic        clk_src,
  input  logic        rst_src_n,
  cdc_hs_tx_if.master bus
);
  typedef enum logic [1:0] {IDLE, REQ, DROP} state_t;

  state_t                state, state_nxt;
  logic                  ack_sync;
  logic                  in_ready_c;
  logic                  accept;
  logic                  req_q, req_nxt;
  logic                  xfer_q, xfer_nxt;
  logic [DATA_WIDTH-1:0] data_q, data_nxt;

  generate
    if (NUM_SYNC_STAGES == 0) begin : g_nosync
      assign ack_sync = bus.ack_in;
    end else begin : g_sync
      (* ASYNC_REG = "TRUE" *) logic [NUM_SYNC_STAGES-1:0] sync_q;
      always_ff @(posedge clk_src or negedge rst_src_n) begin
        if (!rst_src_n) begin
          sync_q <= '0;
        end else begin
          sync_q[0] <= bus.ack_in;
          for (int i = 1; i < NUM_SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
        end
      end
      assign ack_sync = sync_q[NUM_SYNC_STAGES-1];
    end
  endgenerate

`ifdef CDC_HS_TX_SKID_EN
  logic                  skid_valid, skid_valid_nxt;
  logic [DATA_WIDTH-1:0] skid_data;
  // While a word is in flight the skid slot decides readiness; in IDLE a stale ack still blocks.
  assign in_ready_c = (state == IDLE) ? (!ack_sync && !skid_valid) : !skid_valid;
`else
  assign in_ready_c = (state == IDLE) && !ack_sync;
`endif

  assign accept = bus.in_valid && in_ready_c;

  always_comb begin
    state_nxt = state;
    req_nxt   = req_q;
    xfer_nxt  = 1'b0;
    data_nxt  = data_q;
`ifdef CDC_HS_TX_SKID_EN
    skid_valid_nxt = skid_valid;
    if (accept && (state != IDLE)) skid_valid_nxt = 1'b1;
`endif
    unique case (state)
      IDLE: begin
`ifdef CDC_HS_TX_SKID_EN
        // A word parked at the DROP exit launches here; accept is impossible while it is parked.
        if (skid_valid && !ack_sync) begin
          data_nxt       = skid_data;
          req_nxt        = 1'b1;
          state_nxt      = REQ;
          skid_valid_nxt = 1'b0;
        end
`endif
        if (accept) begin
          data_nxt  = bus.in_data;
          req_nxt   = 1'b1;
          state_nxt = REQ;
        end
      end
      REQ: begin
        if (ack_sync) begin
          req_nxt   = 1'b0;
          state_nxt = DROP;
        end
      end
      DROP: begin
        if (!ack_sync) begin
          xfer_nxt  = 1'b1;
          state_nxt = IDLE;
`ifdef CDC_HS_TX_SKID_EN
          if (skid_valid) begin
            data_nxt       = skid_data;
            req_nxt        = 1'b1;
            state_nxt      = REQ;
            skid_valid_nxt = 1'b0;
          end
`endif
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_src or negedge rst_src_n) begin
    if (!rst_src_n) begin
      state  <= IDLE;
      req_q  <= 1'b0;
      xfer_q <= 1'b0;
      data_q <= '0;
    end else begin
      state  <= state_nxt;
      req_q  <= req_nxt;
      xfer_q <= xfer_nxt;
      data_q <= data_nxt;
    end
  end

`ifdef CDC_HS_TX_SKID_EN
  always_ff @(posedge clk_src or negedge rst_src_n) begin
    if (!rst_src_n) skid_valid <= 1'b0;
    else            skid_valid <= skid_valid_nxt;
  end

  always_ff @(posedge clk_src) begin
    if (accept && (state != IDLE)) skid_data <= bus.in_data;
  end
`endif

  assign bus.in_ready  = in_ready_c;
  assign bus.req_out   = req_q;
  assign bus.data_out  = data_q;
  assign bus.busy      = (state != IDLE);
  assign bus.xfer_done = xfer_q;
endmodule
